// File: rtl/sprite_slot_if.sv
// Handshake bundle between the sprite slot scheduler and the sprite draw pipeline.
// The master side requests scans and accepts offered slots; the slave side is the scheduler.
interface sprite_slot_if;
    logic       start;
    logic [3:0] active;
    logic       ready;
    logic [1:0] selector;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] served_mask;
    logic       timeout_flag;

    modport master (
        output start, active, ready,
        input  selector, valid, busy, done, served_mask, timeout_flag
    );

    modport slave (
        input  start, active, ready,
        output selector, valid, busy, done, served_mask, timeout_flag
    );
endinterface

// File: rtl/sprite_slot_scheduler.sv
// Walks the enabled sprite slots in ascending order, settling the coordinate mux before
// offering each slot over valid/ready and skipping consumers that stall past the timeout.
module sprite_slot_scheduler #(
    parameter int NUM_SLOTS     = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int TIMEOUT       = 16
) (
    input logic          clk,
    input logic          reset,
    sprite_slot_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_OFFER  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST   = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit         HAS_TIMEOUT = (TIMEOUT != 0);

    logic [1:0] state;
    logic [3:0] active_q;
    logic [3:0] settle_cnt;
    logic [7:0] wait_cnt;
    logic [2:0] first_slot;
    logic [2:0] next_slot;
    logic       give_up;

    // Returns {found, index} of the lowest set bit of mask at or above position from.
    function automatic logic [2:0] lowest_from(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign first_slot = lowest_from(bus.active, 3'd0);
    assign next_slot  = lowest_from(active_q, {1'b0, bus.selector} + 3'd1);
    assign give_up    = HAS_TIMEOUT && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            active_q         <= 4'd0;
            settle_cnt       <= 4'd0;
            wait_cnt         <= 8'd0;
            bus.selector     <= 2'd0;
            bus.valid        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.served_mask  <= 4'd0;
            bus.timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        active_q         <= bus.active;
                        bus.served_mask  <= 4'd0;
                        bus.timeout_flag <= 1'b0;
                        if (first_slot[2]) begin
                            bus.selector <= first_slot[1:0];
                            settle_cnt   <= 4'd0;
                            bus.busy     <= 1'b1;
                            state        <= S_SETTLE;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        wait_cnt  <= 8'd0;
                        bus.valid <= 1'b1;
                        state     <= S_OFFER;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_OFFER: begin
                    // An accept on the timeout edge wins over the skip.
                    if (bus.ready || give_up) begin
                        if (bus.ready) bus.served_mask[bus.selector] <= 1'b1;
                        else           bus.timeout_flag <= 1'b1;
                        bus.valid <= 1'b0;
                        if (next_slot[2]) begin
                            bus.selector <= next_slot[1:0];
                            settle_cnt   <= 4'd0;
                            state        <= S_SETTLE;
                        end else begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_slot_scheduler.sv
// Self-checking bench for sprite_slot_scheduler: directed scenarios plus random traffic,
// every cycle compared against a slot-queue reference model.
module tb_sprite_slot_scheduler;
    localparam int SETTLE = 1;
    localparam int TMO    = 16;

    logic clk;
    logic reset;
    sprite_slot_if bus();

    sprite_slot_scheduler #(.NUM_SLOTS(4), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the scan is a queue of slots still to visit and the age of the head slot.
    bit         m_scan;
    bit         m_done;
    int         m_q[$];
    int         m_t;
    logic [1:0] m_sel;
    logic [3:0] m_served;
    logic       m_tflag;

    task automatic model_step();
        bit adv;
        adv = 1'b0;
        if (reset) begin
            m_scan = 0; m_done = 0; m_q.delete(); m_t = 0;
            m_sel = 2'd0; m_served = 4'd0; m_tflag = 1'b0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_scan) begin
            if (m_t < SETTLE) begin
                m_t++;
            end else begin
                if (bus.ready) begin
                    m_served[m_sel] = 1'b1;
                    adv = 1'b1;
                end else if (TMO != 0 && (m_t - SETTLE) == TMO - 1) begin
                    m_tflag = 1'b1;
                    adv = 1'b1;
                end else begin
                    m_t++;
                end
                if (adv) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_scan = 0;
                        m_done = 1;
                    end else begin
                        m_sel = 2'(m_q[0]);
                        m_t = 0;
                    end
                end
            end
        end else if (bus.start) begin
            m_served = 4'd0;
            m_tflag  = 1'b0;
            m_q.delete();
            for (int i = 0; i < 4; i++) if (bus.active[i]) m_q.push_back(i);
            if (m_q.size() == 0) begin
                m_done = 1;
            end else begin
                m_scan = 1;
                m_sel = 2'(m_q[0]);
                m_t = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic compare_all();
        check("selector",     32'(bus.selector),     32'(m_sel));
        check("valid",        32'(bus.valid),        32'(m_scan && (m_t >= SETTLE)));
        check("busy",         32'(bus.busy),         32'(m_scan));
        check("done",         32'(bus.done),         32'(m_done));
        check("served_mask",  32'(bus.served_mask),  32'(m_served));
        check("timeout_flag", 32'(bus.timeout_flag), 32'(m_tflag));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_start(input logic [3:0] act);
        bus.active = act;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    initial begin
        int n;
        int hold;
        bit stalled;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.active = 4'd0;
        bus.ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick();

        // All four slots, consumer always ready.
        bus.ready = 1'b1;
        pulse_start(4'b1111);
        n = 0;
        for (int k = 0; k < 20 && !bus.done; k++) begin
            tick();
            n++;
        end
        check("full_latency", 32'(n), 32'd8);
        check("full_served", 32'(bus.served_mask), 32'h0F);
        repeat (2) tick();

        // Sparse slots 1 and 3.
        pulse_start(4'b1010);
        repeat (6) tick();
        check("sparse_served", 32'(bus.served_mask), 32'h0A);
        check("sparse_tflag", 32'(bus.timeout_flag), 32'd0);
        tick();

        // Nothing enabled: done on the cycle after start, never busy.
        pulse_start(4'b0000);
        check("empty_done", 32'(bus.done), 32'd1);
        check("empty_busy", 32'(bus.busy), 32'd0);
        tick();
        check("empty_served", 32'(bus.served_mask), 32'd0);

        // Slot 0 stalls into timeout, slot 1 is accepted.
        bus.ready = 1'b0;
        pulse_start(4'b0011);
        for (int k = 0; k < 25; k++) begin
            bus.ready = (bus.selector == 2'd1);
            tick();
        end
        check("tmo_served", 32'(bus.served_mask), 32'h02);
        check("tmo_flag", 32'(bus.timeout_flag), 32'd1);

        // Back-pressure on slot 2 for five cycles, with a start pulsed mid-scan.
        bus.ready = 1'b1;
        pulse_start(4'b1111);
        hold = 0;
        for (int k = 0; k < 20; k++) begin
            stalled = bus.valid && (bus.selector == 2'd2) && (hold < 5);
            bus.ready = !stalled;
            bus.start = (k == 3);
            tick();
            if (stalled) begin
                hold++;
                check("bp_valid_held", 32'(bus.valid), 32'd1);
                check("bp_sel_held", 32'(bus.selector), 32'd2);
            end
        end
        bus.start = 1'b0;
        check("bp_stall_len", 32'(hold), 32'd5);
        check("bp_served", 32'(bus.served_mask), 32'h0F);
        check("bp_tflag", 32'(bus.timeout_flag), 32'd0);

        // Reset in the middle of an offer, then a clean scan.
        bus.ready = 1'b0;
        pulse_start(4'b0001);
        repeat (4) tick();
        check("mid_valid", 32'(bus.valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        tick();
        bus.ready = 1'b1;
        pulse_start(4'b0001);
        repeat (3) tick();
        check("mid_clean_served", 32'(bus.served_mask), 32'h01);

        // Random traffic: mostly-ready consumer, then a sluggish one that hits timeouts.
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            bus.start  = ($urandom_range(0, 5) == 0);
            bus.active = 4'($urandom);
            bus.ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        for (int k = 0; k < 600; k++) begin
            reset      = ($urandom_range(0, 299) == 0);
            bus.start  = ($urandom_range(0, 5) == 0);
            bus.active = 4'($urandom);
            bus.ready  = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
